// File: rtl/receive_buffer_if.sv
// rtl/receive_buffer_if.sv - processor-side bus and serial line bundle for the SPART receiver
//
// Purpose : groups the baud tick, register-select strobes, serial input and
//           status flags shared between the SPART bus logic and receive_buffer.
// Signals :
//   enable      1-cycle oversample tick from the baud generator
//   iocs        chip select
//   iorw        1 = read, 0 = write
//   ioaddr      register address, 2'b00 = data register
//   rxd         asynchronous serial input, idle high
//   rda         receive data available
//   parity_err  parity of the buffered byte was wrong
//   frame_err   stop bit of the buffered byte sampled 0
//   overrun     a completed frame was discarded while rda=1 (sticky until read)
// The 8-bit tristate databus is a plain inout port on receive_buffer.

interface receive_buffer_if;
    logic       enable;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rxd;
    logic       rda;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output enable,
        output iocs,
        output iorw,
        output ioaddr,
        output rxd,
        input  rda,
        input  parity_err,
        input  frame_err,
        input  overrun
    );

    modport slave (
        input  enable,
        input  iocs,
        input  iorw,
        input  ioaddr,
        input  rxd,
        output rda,
        output parity_err,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/receive_buffer.sv
// rtl/receive_buffer.sv - SPART receiver: deserialises RxD and holds one byte for the processor
//
// Purpose : oversampled UART receiver. Frame = start(0), DATA_BITS data bits
//           LSB first, optional even parity bit, one stop bit(1). The last
//           completed byte is held in a single buffer register with status.
// Ports   :
//   clk      in     system clock
//   rst      in     asynchronous active-low reset
//   bus      slave  receive_buffer_if (enable tick, iocs/iorw/ioaddr, rxd, status flags)
//   databus  inout  8-bit data bus, driven with the buffer only on a data read
// Parameters:
//   OVERSAMPLE  enable ticks per bit period
//   DATA_BITS   data bits per frame (1..8), upper databus bits read 0
//   PARITY_EN   1: parity bit present and checked, 0: no parity bit

module receive_buffer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    receive_buffer_if.slave   bus,
    inout  wire  [7:0]        databus
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= bus.rxd;
            r_rxs     <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_next_state;
    logic [TW-1:0]        r_tick;
    logic [3:0]           r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_pend;
    logic [7:0]           r_rx_buf;
    logic                 r_rda;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    // Strobes decoded from the state by the output process
    logic w_tick_clr;
    logic w_tick_inc;
    logic w_bit_clr;
    logic w_shift_en;
    logic w_par_en;
    logic w_load;

    logic w_mid_start;
    logic w_mid_bit;
    logic w_last_bit;
    logic w_read;
    logic [DATA_BITS:0]   w_shift_wide;
    logic [DATA_BITS-1:0] w_shift_next;
    logic [7:0]           w_rx_byte;

    assign w_mid_start = (r_tick == TICK_HALF);
    assign w_mid_bit   = (r_tick == TICK_LAST);
    assign w_last_bit  = (r_bitcnt == BIT_LAST);
    assign w_read      = bus.iocs & bus.iorw & (bus.ioaddr == 2'b00);

    // New sample enters at the MSB; after DATA_BITS shifts the first (LSB)
    // bit of the frame has walked down to bit 0. The widened form keeps the
    // expression legal for DATA_BITS = 1.
    assign w_shift_wide = {r_rxs, r_shift} >> 1;
    assign w_shift_next = w_shift_wide[DATA_BITS-1:0];
    assign w_rx_byte    = 8'(r_shift);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic, every transition waits for an enable tick
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (bus.enable) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) w_next_state = S_START;
                end
                S_START: begin
                    // A start bit still low at mid-bit is genuine, otherwise a glitch
                    if (w_mid_start) w_next_state = r_rxs ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_mid_bit && w_last_bit)
                        w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (w_mid_bit) w_next_state = S_STOP;
                end
                S_STOP: begin
                    if (w_mid_bit) w_next_state = S_IDLE;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode into datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_tick_clr = 1'b0;
        w_tick_inc = 1'b0;
        w_bit_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_load     = 1'b0;
        if (bus.enable) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) w_tick_clr = 1'b1;
                end
                S_START: begin
                    if (w_mid_start) begin
                        w_tick_clr = 1'b1;
                        w_bit_clr  = 1'b1;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    // Counting from mid-start, tick OVERSAMPLE-1 lands mid-bit;
                    // clearing there is the counter wrap.
                    if (w_mid_bit) begin
                        w_tick_clr = 1'b1;
                        w_shift_en = (r_state == S_DATA);
                        w_par_en   = (r_state == S_PARITY);
                        w_load     = (r_state == S_STOP);
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick      <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_perr_pend <= 1'b0;
        end else begin
            if (w_tick_clr) begin
                r_tick <= '0;
            end else if (w_tick_inc) begin
                r_tick <= r_tick + 1'b1;
            end

            if (w_bit_clr) begin
                r_bitcnt <= '0;
            end else if (w_shift_en) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end

            if (w_shift_en) begin
                r_shift <= w_shift_next;
            end

            // Pending parity error: sampled parity bit versus even parity of data
            if (w_bit_clr) begin
                r_perr_pend <= 1'b0;
            end else if (w_par_en && (PARITY_EN != 0)) begin
                r_perr_pend <= r_rxs ^ (^r_shift);
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding buffer and status flags
    // ------------------------------------------------------------------
    // A load is accepted when the buffer is empty or being read in the same
    // cycle (the read returns the old byte, the new one replaces it and rda
    // stays set). A load into an unread buffer is dropped and flags overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_buf     <= 8'h00;
            r_rda        <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load && (!r_rda || w_read)) begin
                r_rx_buf     <= w_rx_byte;
                r_parity_err <= r_perr_pend;
                r_frame_err  <= ~r_rxs;
                r_rda        <= 1'b1;
            end else if (w_read) begin
                r_rda <= 1'b0;
            end

            if (w_read) begin
                r_overrun <= 1'b0;
            end else if (w_load && r_rda) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.rda        = r_rda;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;

    assign databus = w_read ? r_rx_buf : 8'hzz;

endmodule

// File: tb/tb_receive_buffer.sv
// tb/tb_receive_buffer.sv - self-checking bench for receive_buffer

module tb_receive_buffer;

    localparam int OS        = 16;
    localparam int EN_DIV    = 4;
    localparam int BIT_CLKS  = OS * EN_DIV;

    logic       clk;
    logic       rst;
    wire  [7:0] databus;

    receive_buffer_if bus ();

    receive_buffer #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (8),
        .PARITY_EN  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .databus (databus)
    );

    int n_checks;
    int n_pass;
    int en_cnt;

    // Reference model of the processor-visible state
    logic [7:0] exp_buf;
    logic       exp_rda;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_ovr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one enable pulse every EN_DIV clocks
    initial begin
        bus.enable = 1'b0;
        en_cnt     = 0;
        forever begin
            @(negedge clk);
            en_cnt     = (en_cnt + 1) % EN_DIV;
            bus.enable = (en_cnt == 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_rda"},  {31'd0, bus.rda},        {31'd0, exp_rda});
        check({tag, "_perr"}, {31'd0, bus.parity_err}, {31'd0, exp_perr});
        check({tag, "_ferr"}, {31'd0, bus.frame_err},  {31'd0, exp_ferr});
        check({tag, "_ovr"},  {31'd0, bus.overrun},    {31'd0, exp_ovr});
    endtask

    task automatic line(input logic b, input int clks);
        bus.rxd = b;
        repeat (clks) @(negedge clk);
    endtask

    // Model: a completed frame loads only into an empty buffer
    task automatic model_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (!exp_rda) begin
            exp_buf  = d;
            exp_perr = bad_par;
            exp_ferr = bad_stop;
            exp_rda  = 1'b1;
        end else begin
            exp_ovr = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        line(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) line(d[i], BIT_CLKS);
        line((^d) ^ bad_par, BIT_CLKS);
        if (bad_stop) begin
            // Return high shortly after mid-stop so the tail is rejected as a glitch
            line(1'b0, BIT_CLKS * 3 / 4);
            line(1'b1, BIT_CLKS / 4);
        end else begin
            line(1'b1, BIT_CLKS);
        end
        line(1'b1, 2 * BIT_CLKS);
        model_frame(d, bad_par, bad_stop);
    endtask

    task automatic do_read(input string tag);
        bus.iocs   = 1'b1;
        bus.iorw   = 1'b1;
        bus.ioaddr = 2'b00;
        #1;
        check({tag, "_data"}, {24'd0, databus}, {24'd0, exp_buf});
        @(negedge clk);
        bus.iocs = 1'b0;
        exp_rda  = 1'b0;
        exp_ovr  = 1'b0;
        check_flags({tag, "_after"});
    endtask

    task automatic other_access(input string tag);
        bus.iocs = 1'b1;
        if ($urandom_range(0, 1) == 0) begin
            bus.iorw   = 1'b0;
            bus.ioaddr = 2'($urandom_range(0, 3));
        end else begin
            bus.iorw   = 1'b1;
            bus.ioaddr = 2'($urandom_range(1, 3));
        end
        @(negedge clk);
        bus.iocs = 1'b0;
        bus.iorw = 1'b0;
        @(negedge clk);
        check_flags(tag);
    endtask

    initial begin
        logic [7:0] d;
        bit bp;
        bit bs;

        n_checks   = 0;
        n_pass     = 0;
        exp_buf    = 8'h00;
        exp_rda    = 1'b0;
        exp_perr   = 1'b0;
        exp_ferr   = 1'b0;
        exp_ovr    = 1'b0;
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        bus.rxd    = 1'b1;
        rst        = 1'b0;

        // Reset held with activity on the line
        for (int i = 0; i < 40; i++) begin
            bus.rxd = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check_flags("reset");
        bus.rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge clk);
        check_flags("post_reset");
        do_read("reset_rd");

        // Clean byte
        send_frame(8'hA5, 1'b0, 1'b0);
        check_flags("a5");
        do_read("a5_rd");

        // Parity error, then frame error
        send_frame(8'h3C, 1'b1, 1'b0);
        check_flags("3c");
        do_read("3c_rd");
        send_frame(8'h01, 1'b0, 1'b1);
        check_flags("01");
        do_read("01_rd");

        // Overrun
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        check_flags("ovr");
        do_read("ovr_rd");

        // Glitch on the line shorter than half a bit
        line(1'b0, EN_DIV * OS / 4);
        line(1'b1, 2 * BIT_CLKS);
        check_flags("glitch");
        check("glitch_state", {29'd0, dut.r_state}, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0);
        check_flags("5a");
        do_read("5a_rd");

        // Reset in the middle of a frame
        line(1'b0, BIT_CLKS);
        line(1'b1, 3 * BIT_CLKS / 2);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        bus.rxd = 1'b1;
        rst = 1'b1;
        line(1'b1, 3 * BIT_CLKS);
        check_flags("abort");
        send_frame(8'h42, 1'b0, 1'b0);
        check_flags("42");
        do_read("42_rd");

        // Randomised frames with random errors, skipped reads and stray accesses
        for (int n = 0; n < 8; n++) begin
            d  = 8'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            send_frame(d, bp, bs);
            check_flags("rnd");
            if ($urandom_range(0, 2) == 0) other_access("rnd_other");
            if ($urandom_range(0, 2) != 0) do_read("rnd_rd");
        end
        do_read("final_rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
